// File: rtl/mem_wb_stage_pkg.sv
// Shared CPU definitions: writeback source selects and load funct3 codes.
// Also holds the opcode and funct definitions used by the other pipeline stages.
package mem_wb_stage_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_RSVD = 2'd3;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_JAL  = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;

endpackage

// File: rtl/mem_wb_stage_load_extend.sv
// Load data extraction: picks the addressed byte/halfword of a memory word
// and sign- or zero-extends it to XLEN.
module load_extend
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      offset,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (offset)
      2'd0: byte_sel = word[7:0];
      2'd1: byte_sel = word[15:8];
      2'd2: byte_sel = word[23:16];
      2'd3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = offset[1] ? word[31:16] : word[15:0];
  end

  // Unrecognised load types fall back to passing the full word.
  always_comb begin
    data = word;
    case (funct3)
      F3_LB:   data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LBU:  data = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LHU:  data = {{(XLEN-16){1'b0}}, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction, register-file write port,
// forwarding source and retired-instruction counter.
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [4:0]       in_rd,
  input  logic             in_reg_we,
  input  logic [1:0]       in_wb_sel,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [2:0]       in_funct3,
  input  logic [XLEN-1:0]  dmem_dout,
  input  logic             stall,
  input  logic             flush,
  output logic             wb_we,
  output logic [4:0]       wb_wa,
  output logic [XLEN-1:0]  wb_wd,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret
);

  logic             valid;
  logic [4:0]       rd;
  logic             reg_we;
  logic [1:0]       wb_sel;
  logic [XLEN-1:0]  alu;
  logic [XLEN-1:0]  pc;
  logic [2:0]       funct3;
  logic             hold_valid;
  logic [XLEN-1:0]  hold_data;
  logic [CNT_W-1:0] instret_q;

  // dmem_dout is only valid in the first WB cycle, so a stalled load keeps
  // its own copy until the stage is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      rd         <= '0;
      reg_we     <= 1'b0;
      wb_sel     <= WB_SEL_ALU;
      alu        <= '0;
      pc         <= '0;
      funct3     <= '0;
      hold_valid <= 1'b0;
      hold_data  <= '0;
      instret_q  <= '0;
    end else begin
      if (valid && !stall)
        instret_q <= instret_q + CNT_W'(1);
      if (!stall) begin
        valid      <= in_valid & ~flush;
        rd         <= in_rd;
        reg_we     <= in_reg_we;
        wb_sel     <= in_wb_sel;
        alu        <= in_alu;
        pc         <= in_pc;
        funct3     <= in_funct3;
        hold_valid <= 1'b0;
      end else if (!hold_valid) begin
        hold_valid <= 1'b1;
        hold_data  <= dmem_dout;
      end
    end
  end

  logic [XLEN-1:0] load_word;
  logic [XLEN-1:0] load_data;
  logic [XLEN-1:0] wd;
  logic            writes_reg;

  assign load_word = hold_valid ? hold_data : dmem_dout;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .funct3 (funct3),
    .offset (alu[1:0]),
    .word   (load_word),
    .data   (load_data)
  );

  always_comb begin
    wd = alu;
    case (wb_sel)
      WB_SEL_LOAD: wd = load_data;
      WB_SEL_PC4:  wd = pc + XLEN'(4);
      default:     wd = alu;
    endcase
  end

  assign writes_reg = valid & reg_we & (rd != 5'd0);

  assign wb_we     = writes_reg & ~stall;
  assign wb_wa     = rd;
  assign wb_wd     = wd;
  assign fwd_valid = writes_reg;
  assign fwd_rd    = rd;
  assign fwd_data  = wd;
  assign instret   = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_mem_wb_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic [1:0]  in_wb_sel;
  logic [31:0] in_alu;
  logic [31:0] in_pc;
  logic [2:0]  in_funct3;
  logic [31:0] dmem_dout;
  logic        stall;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_wa;
  logic [31:0] wb_wd;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [63:0] instret;

  mem_wb_stage #(.XLEN(32), .CNT_W(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_rd     (in_rd),
    .in_reg_we (in_reg_we),
    .in_wb_sel (in_wb_sel),
    .in_alu    (in_alu),
    .in_pc     (in_pc),
    .in_funct3 (in_funct3),
    .dmem_dout (dmem_dout),
    .stall     (stall),
    .flush     (flush),
    .wb_we     (wb_we),
    .wb_wa     (wb_wa),
    .wb_wd     (wb_wd),
    .fwd_valid (fwd_valid),
    .fwd_rd    (fwd_rd),
    .fwd_data  (fwd_data),
    .instret   (instret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  // Model of the instruction sitting in WB and the memory word it loaded.
  bit          m_init = 1'b0;
  bit          m_captured = 1'b0;
  bit          m_valid = 1'b0;
  logic [4:0]  m_rd = '0;
  bit          m_we = 1'b0;
  logic [1:0]  m_sel = '0;
  logic [31:0] m_alu = '0;
  logic [31:0] m_pc = '0;
  logic [2:0]  m_f3 = '0;
  logic [31:0] m_word = '0;
  logic [63:0] m_instret = '0;

  logic [31:0] pend_word = '0;
  bit          junk_fixed = 1'b0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] word);
    logic [31:0] b;
    logic [31:0] h;
    b = (word >> (off * 8)) & 32'hFF;
    h = (word >> (off[1] * 16)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return word;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_init = 1'b1;
      m_valid = 1'b0; m_rd = '0; m_we = 1'b0; m_sel = '0;
      m_alu = '0; m_pc = '0; m_f3 = '0; m_word = '0;
      m_instret = '0;
      m_captured = 1'b0;
    end else begin
      if (m_valid && !stall) m_instret = m_instret + 64'd1;
      if (!stall) begin
        m_valid = in_valid && !flush;
        m_rd = in_rd; m_we = in_reg_we; m_sel = in_wb_sel;
        m_alu = in_alu; m_pc = in_pc; m_f3 = in_funct3;
        m_word = pend_word;
      end
      m_captured = !stall;
    end
  end

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    logic [31:0] exp_wd;
    logic        exp_fwd;
    if (m_init) begin
      exp_wd = (m_sel == 2'd1) ? model_load(m_f3, m_alu[1:0], m_word) :
               (m_sel == 2'd2) ? m_pc + 32'd4 : m_alu;
      exp_fwd = m_valid && m_we && (m_rd != 5'd0);
      check_output("model wb_we", 64'(wb_we), 64'(exp_fwd && !stall));
      check_output("model wb_wa", 64'(wb_wa), 64'(m_rd));
      check_output("model wb_wd", 64'(wb_wd), 64'(exp_wd));
      check_output("model fwd_valid", 64'(fwd_valid), 64'(exp_fwd));
      check_output("model fwd_rd", 64'(fwd_rd), 64'(m_rd));
      check_output("model fwd_data", 64'(fwd_data), 64'(exp_wd));
      check_output("model instret", instret, m_instret);
    end
  end

  // Advance one cycle, present the memory response, then drive new inputs.
  task automatic apply_stimulus(input bit v, input logic [4:0] rd, input bit we,
                                input logic [1:0] sel, input logic [31:0] alu,
                                input logic [31:0] pc, input logic [2:0] f3,
                                input logic [31:0] word, input bit st, input bit fl,
                                input bit r);
    @(posedge clk);
    #1;
    dmem_dout = m_captured ? pend_word : (junk_fixed ? 32'hDEAD_BEEF : 32'($urandom));
    in_valid = v; in_rd = rd; in_reg_we = we; in_wb_sel = sel;
    in_alu = alu; in_pc = pc; in_funct3 = f3; pend_word = word;
    stall = st; flush = fl; rst = r;
  endtask

  task automatic bubble(input bit st, input bit fl, input bit r);
    apply_stimulus(1'b0, 5'd0, 1'b0, 2'd0, 32'd0, 32'd0, 3'd0, 32'd0, st, fl, r);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_rd = '0; in_reg_we = 1'b0; in_wb_sel = '0;
    in_alu = '0; in_pc = '0; in_funct3 = '0; dmem_dout = '0;
    stall = 1'b0; flush = 1'b0;

    bubble(1'b0, 1'b0, 1'b1);
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("reset wb_we", 64'(wb_we), 64'd0);
    check_output("reset fwd_valid", 64'(fwd_valid), 64'd0);
    check_output("reset wb_wd", 64'(wb_wd), 64'd0);
    check_output("reset instret", instret, 64'd0);

    apply_stimulus(1'b1, 5'd5, 1'b1, 2'd1, 32'h0000_1003, 32'h100, 3'b000, 32'h80FF_1234, 1'b0, 1'b0, 1'b0);
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("LB wd", 64'(wb_wd), 64'hFFFF_FF80);
    check_output("LB we", 64'(wb_we), 64'd1);
    check_output("LB wa", 64'(wb_wa), 64'd5);

    apply_stimulus(1'b1, 5'd6, 1'b1, 2'd1, 32'h0000_2002, 32'h104, 3'b101, 32'hBEEF_0000, 1'b0, 1'b0, 1'b0);
    apply_stimulus(1'b1, 5'd6, 1'b1, 2'd1, 32'h0000_2002, 32'h108, 3'b001, 32'hBEEF_0000, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("LHU wd", 64'(wb_wd), 64'h0000_BEEF);
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("LH wd", 64'(wb_wd), 64'hFFFF_BEEF);

    apply_stimulus(1'b1, 5'd1, 1'b1, 2'd2, 32'h0, 32'hFFFF_FFFC, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("JAL wd", 64'(wb_wd), 64'h0);
    check_output("JAL we", 64'(wb_we), 64'd1);

    junk_fixed = 1'b1;
    apply_stimulus(1'b1, 5'd7, 1'b1, 2'd1, 32'h0000_3000, 32'h110, 3'b010, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bubble(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      check_output("LW stalled we", 64'(wb_we), 64'd0);
      check_output("LW stalled wd", 64'(wb_wd), 64'h1234_5678);
      check_output("LW stalled instret", instret, 64'd4);
    end
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("LW release we", 64'(wb_we), 64'd1);
    check_output("LW release wd", 64'(wb_wd), 64'h1234_5678);
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("LW after we", 64'(wb_we), 64'd0);
    check_output("LW after instret", instret, 64'd5);
    junk_fixed = 1'b0;

    apply_stimulus(1'b1, 5'd0, 1'b1, 2'd0, 32'd100, 32'h114, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("rd0 we", 64'(wb_we), 64'd0);
    check_output("rd0 fwd_valid", 64'(fwd_valid), 64'd0);
    check_output("rd0 wd", 64'(wb_wd), 64'd100);
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("rd0 instret", instret, 64'd6);

    apply_stimulus(1'b1, 5'd3, 1'b1, 2'd0, 32'd77, 32'h118, 3'b000, 32'h0, 1'b0, 1'b1, 1'b0);
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("flush fwd_valid", 64'(fwd_valid), 64'd0);
    check_output("flush we", 64'(wb_we), 64'd0);
    apply_stimulus(1'b1, 5'd9, 1'b1, 2'd0, 32'd55, 32'h11C, 3'b000, 32'h0, 1'b0, 1'b0, 1'b0);
    bubble(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check_output("stall fwd_valid", 64'(fwd_valid), 64'd1);
    check_output("stall we", 64'(wb_we), 64'd0);
    bubble(1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check_output("stall+flush fwd_valid", 64'(fwd_valid), 64'd1);
    bubble(1'b1, 1'b0, 1'b1);
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("rst-stall we", 64'(wb_we), 64'd0);
    check_output("rst-stall fwd_valid", 64'(fwd_valid), 64'd0);
    check_output("rst-stall wd", 64'(wb_wd), 64'd0);
    check_output("rst-stall wa", 64'(wb_wa), 64'd0);
    check_output("rst-stall instret", instret, 64'd0);
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check_output("rst-stall instret later", instret, 64'd0);

    for (int i = 0; i < 2000; i++) begin
      apply_stimulus(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
                     1'($urandom), 2'($urandom_range(0, 3)), 32'($urandom),
                     ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : (32'($urandom) & ~32'd3),
                     3'($urandom_range(0, 7)), 32'($urandom),
                     ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) == 0),
                     ($urandom_range(0, 49) == 0));
    end
    bubble(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath and register-data width.
REQ-002 SHALL have parameter CNT_W, default 64, meaning retired-instruction counter width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 in_valid  input  1  memory stage presents an instruction.
REQ-006 in_rd  input  5  destination register index.
REQ-007 in_reg_we  input  1  instruction writes a register.
REQ-008 in_wb_sel  input  2  writeback source: 0 ALU, 1 LOAD, 2 PC+4, 3 reserved (treated as ALU).
REQ-009 in_alu  input  XLEN  ALU result; bits [1:0] are the load byte offset.
REQ-010 in_pc  input  XLEN  instruction PC.
REQ-011 in_funct3  input  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
REQ-012 dmem_dout  input  XLEN  synchronous-read data memory output, valid the cycle after address issue.
REQ-013 stall  input  1  hold WB contents; suppress register write.
REQ-014 flush  input  1  kill the instruction being captured.
REQ-015 wb_we / wb_wa / wb_wd  output  1/5/XLEN  register-file write port (we, wa, wd).
REQ-016 fwd_valid / fwd_rd / fwd_data  output  1/5/XLEN  forwarding source for the execute stage.
REQ-017 instret  output  CNT_W  retired-instruction count.

Function
REQ-018 WB pipeline register SHALL capture valid, rd, reg_we, wb_sel, alu, pc and funct3 on each edge where stall=0; valid captured as in_valid & ~flush.
REQ-019 While stall=1 the WB register SHALL hold; flush during stall SHALL be ignored.
REQ-020 Load data SHALL be taken from dmem_dout in the first WB cycle; on the first stalled cycle it SHALL be latched into a hold register; subsequent stalled cycles and the release cycle SHALL use the held value.
REQ-021 Load extraction SHALL select byte alu[1:0] (LB/LBU) or halfword alu[1] (LH/LHU), sign-extend for LB/LH and zero-extend for LBU/LHU; LW passes the word; unknown funct3 behaves as LW.
REQ-022 wd SHALL be alu (sel 0/3), extracted load (sel 1), or pc+4 modulo 2^XLEN (sel 2).
REQ-023 wb_we SHALL equal valid & reg_we & (rd!=0) & ~stall; combinational from WB state; exactly one write per instruction.
REQ-024 wb_wa SHALL be rd and wb_wd SHALL be wd regardless of wb_we.
REQ-025 fwd_valid SHALL equal valid & reg_we & (rd!=0), including during stall; fwd_rd = rd; fwd_data = wd.
REQ-026 instret SHALL increment by 1 on each edge where valid=1 and stall=0, wrapping modulo 2^CNT_W.
REQ-027 Latency: an instruction captured at edge N SHALL drive wb_we in cycle N..N+1 (the write commits at edge N+1) if unstalled.

Reset
REQ-028 On a rising edge with rst=1: valid, hold-valid flag, hold register and instret SHALL clear to 0; all other WB fields SHALL clear to 0.
REQ-029 rst SHALL override stall and flush; wb_we and fwd_valid SHALL be 0 in the cycle after reset.
REQ-030 Reset mid-stall SHALL discard the stalled instruction with no write and no instret increment.

Structure
REQ-031 wb_sel encodings and load funct3 codes SHALL be constants in the shared CPU package alongside the other opcode/funct definitions.
REQ-032 Load extraction SHALL be one combinational sub-module, load_extend (inputs funct3, offset, word; output XLEN data).

Verification
REQ-033 LB, alu[1:0]=3, dmem_dout=0x80FF_1234 -> wb_wd=0xFFFF_FF80, wb_we=1 for rd=5.
REQ-034 LHU, alu[1:0]=2, dmem_dout=0xBEEF_0000 -> wb_wd=0x0000_BEEF; LH same -> 0xFFFF_BEEF.
REQ-035 JAL, sel=2, pc=0xFFFF_FFFC, rd=1 -> wb_wd=0x0000_0000, wb_we=1.
REQ-036 LW, dmem_dout=0x1234_5678, stall=1 for 3 cycles while dmem_dout changes to 0xDEAD_BEEF -> wb_we=0 while stalled, one write of 0x1234_5678 on release, instret +1 only once.
REQ-037 rd=0 with reg_we=1, alu=100 -> wb_we=0, fwd_valid=0, instret +1.
REQ-038 flush with in_valid=1, then rst asserted mid-stall -> no write, instret stays 0, all outputs 0 next cycle.
